// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

    localparam int OPW = 4;

    localparam logic [OPW-1:0] OP_ADD = 4'd0;
    localparam logic [OPW-1:0] OP_SUB = 4'd1;
    localparam logic [OPW-1:0] OP_MUL = 4'd2;
    localparam logic [OPW-1:0] OP_SHR = 4'd3;
    localparam logic [OPW-1:0] OP_SHL = 4'd4;
    localparam logic [OPW-1:0] OP_DIV = 4'd5;
    localparam logic [OPW-1:0] OP_NOT = 4'd6;
    localparam logic [OPW-1:0] OP_AND = 4'd7;
    localparam logic [OPW-1:0] OP_OR  = 4'd8;
    localparam logic [OPW-1:0] OP_XOR = 4'd9;
    localparam logic [OPW-1:0] OP_INC = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Operand-issue and result handshake bundle between the issue stage, the ALU and the sink.
interface alu_seq_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int RES_WIDTH = 2 * WIDTH;

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [OPW-1:0]       opsel;
    logic                 out_valid;
    logic                 out_ready;
    logic [RES_WIDTH-1:0] result;
    logic                 flag_zero;
    logic                 flag_carry;
    logic                 flag_dbz;

    modport master (
        output in_valid, a, b, opsel, out_ready,
        input  in_ready, out_valid, result, flag_zero, flag_carry, flag_dbz
    );

    modport slave (
        input  in_valid, a, b, opsel, out_ready,
        output in_ready, out_valid, result, flag_zero, flag_carry, flag_dbz
    );

endinterface

// File: rtl/alu_div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
// quotient/remainder show the post-iteration values, valid in the cycle done is high.
module alu_div_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder
    always_comb begin
        trial = {rem_q, quo_q[WIDTH-1]};
        if (trial >= {1'b0, dvs_q}) begin
            rem_step = WIDTH'(trial - {1'b0, dvs_q});
            quo_step = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = trial[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b0};
        end

        done      = busy_q && (cnt_q == CW'(WIDTH - 1));
        quotient  = quo_step;
        remainder = rem_step;

        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;

        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            rem_d  = '0;
            quo_d  = dividend;
            dvs_d  = divisor;
        end else if (busy_q) begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q + CW'(1);
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential WIDTH-bit ALU: handshake FSM, single-cycle datapath and registered
// double-width result; divide is delegated to the iterative divider.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic       clk,
    input logic       rst,
    alu_seq_if.slave  bus
);
    localparam int RES_WIDTH = 2 * WIDTH;

    state_e               state_q, state_d;
    logic [RES_WIDTH-1:0] result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 carry_q, carry_d;
    logic                 dbz_q, dbz_d;

    logic [RES_WIDTH-1:0] a_ext, b_ext, sum, alu_res;
    logic                 alu_carry, alu_dbz, big_shift;
    logic                 div_start, div_done;
    logic [WIDTH-1:0]     div_quo, div_rem;

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.result     = result_q;
    assign bus.flag_zero  = zero_q;
    assign bus.flag_carry = carry_q;
    assign bus.flag_dbz   = dbz_q;

    assign div_start = (state_q == IDLE) && bus.in_valid &&
                       (bus.opsel == OP_DIV) && (bus.b != '0);

    alu_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (bus.a),
        .divisor   (bus.b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Single-cycle ops; divide here only covers the b == 0 shortcut
    always_comb begin
        a_ext     = {{WIDTH{1'b0}}, bus.a};
        b_ext     = {{WIDTH{1'b0}}, bus.b};
        sum       = a_ext + b_ext;
        big_shift = (b_ext >= RES_WIDTH'(WIDTH));
        alu_carry = 1'b0;
        alu_dbz   = 1'b0;
        case (bus.opsel)
            OP_SUB: alu_res = a_ext - b_ext;
            OP_MUL: alu_res = a_ext * b_ext;
            OP_SHR: alu_res = big_shift ? '0 : (a_ext >> bus.b);
            OP_SHL: alu_res = big_shift ? '0 : (a_ext << bus.b);
            OP_DIV: begin
                alu_res = {bus.a, {WIDTH{1'b1}}};
                alu_dbz = 1'b1;
            end
            OP_NOT: alu_res = {{WIDTH{1'b0}}, ~bus.a};
            OP_AND: alu_res = a_ext & b_ext;
            OP_OR:  alu_res = a_ext | b_ext;
            OP_XOR: alu_res = a_ext ^ b_ext;
            OP_INC: begin
                alu_res   = a_ext + RES_WIDTH'(1);
                alu_carry = alu_res[WIDTH];
            end
            default: begin
                alu_res   = sum;
                alu_carry = sum[WIDTH];
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        dbz_d    = dbz_q;
        case (state_q)
            IDLE: begin
                if (div_start) begin
                    state_d = DIV;
                end else if (bus.in_valid) begin
                    state_d  = DONE;
                    result_d = alu_res;
                    zero_d   = (alu_res == '0);
                    carry_d  = alu_carry;
                    dbz_d    = alu_dbz;
                end
            end
            DIV: begin
                if (div_done) begin
                    state_d  = DONE;
                    result_d = {div_rem, div_quo};
                    zero_d   = ({div_rem, div_quo} == '0);
                    carry_d  = 1'b0;
                    dbz_d    = 1'b0;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            dbz_q    <= dbz_d;
        end
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential, parametrised successor to the team's combinational 8-bit ALU. Takes operands through a valid/ready input handshake, executes the same 11-opcode set at WIDTH bits, and returns a registered double-width result with status flags through a valid/ready output handshake. Divide is iterative (one quotient bit per cycle); all other ops complete in one cycle. Sits between an operand-issue stage and a result sink that may stall.

## Interface
Parameters:
- WIDTH, 8, operand width (≥2)
- RES_WIDTH, 2*WIDTH, result width (fixed at 2*WIDTH, not overridable)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- a  in  WIDTH  operand A, unsigned
- b  in  WIDTH  operand B, unsigned
- opsel  in  4  opcode
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- result  out  RES_WIDTH  registered result
- flag_zero  out  1  result == 0
- flag_carry  out  1  add/inc carry-out (bit WIDTH of sum); 0 for other ops
- flag_dbz  out  1  divide with b == 0

## Operation
- Opcodes: 0 add, 1 sub, 2 mul, 3 logical shift right, 4 shift left, 5 divide, 6 not, 7 and, 8 or, 9 xor, 10 increment A, 11–15 treated as add.
- All operands zero-extended to RES_WIDTH before computation unless stated otherwise.
- add/inc: a+b / a+1, zero-extended; flag_carry = bit WIDTH.
- sub: (a − b) mod 2^RES_WIDTH (borrow gives all-ones upper bits).
- mul: full unsigned product a*b.
- shifts: by b; if b ≥ WIDTH result = 0. Shift-left keeps bits above WIDTH (a << b within RES_WIDTH).
- not: {WIDTH zeros, ~a}. and/or/xor: zero-extended WIDTH-bit result.
- divide: result = {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}. b == 0: quotient all-ones, remainder = a, flag_dbz = 1, no iteration.
- FSM states: IDLE, DIV, DONE.
  - IDLE: in_ready = 1. On accept: non-div or dbz → compute, register, go DONE. Divide with b≠0 → load divider, go DIV.
  - DIV: iterate WIDTH cycles (restoring, MSB first); after last iteration register result, go DONE.
  - DONE: out_valid = 1; result/flags held stable. out_valid && out_ready → IDLE.
- in_ready = 1 only in IDLE; out_valid = 1 only in DONE. No input accept in DONE, even when out_ready is high.
- Reset (any state, including mid-divide): state IDLE, result 0, all flags 0, out_valid 0, in_ready 1 from the first cycle after reset; in-flight op discarded.

## Timing
- Non-div and dbz: accept edge N → out_valid high from cycle N+1.
- Divide (b≠0): accept edge N → out_valid high from cycle N+WIDTH+1.
- Result held indefinitely under out_ready = 0; minimum issue interval 2 cycles (non-div), WIDTH+2 cycles (div).
- flag_zero evaluated on final RES_WIDTH result, valid with out_valid.
- Inputs a/b/opsel sampled only on the accept edge; may change freely afterward.

## Structure
- Package alu_pkg: opcode localparams (OP_ADD … OP_INC), FSM state enum.
- Sub-module alu_div_iter: WIDTH-parametrised restoring divider with start/done, quotient and remainder outputs; instantiated once. Top owns FSM, single-cycle datapath, output registers.

## Test plan
- WIDTH=8, add a=200, b=100 → result 0x012C, flag_carry 1, out_valid one cycle after accept.
- sub a=5, b=7 → result 0xFFFE, flag_zero 0; xor a=0xAA, b=0xAA → result 0, flag_zero 1.
- mul a=255, b=255 → 0xFE01; shl a=0x81, b=4 → 0x0810; shr b=9 → 0.
- div a=200, b=7 → result {0x04, 0x1C}, out_valid exactly 9 cycles after accept; div b=0, a=0x33 → {0x33, 0xFF}, flag_dbz 1, latency 1.
- Hold out_ready=0 for 10 cycles with in_valid high → result stable, in_ready 0, no second accept; release → next op accepted the cycle after the output handshake.
- Assert rst 3 cycles into a divide → next cycle out_valid 0, result 0, in_ready 1; a fresh add completes normally.
